// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase-step sequencer.
// Optional build macro PLL_PHASE_IRQ_EN is consumed by pll_phase_step_ctrl.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    STEP      = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4,
    NEXT      = 3'd5
  } state_e;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CMD    = 3'd1;
  localparam logic [2:0] ADDR_REMAIN = 3'd2;

  localparam int STS_BUSY = 0;
  localparam int STS_LOCK = 1;
  localparam int STS_DONE = 2;
  localparam int STS_REJ  = 3;
  localparam int STS_TMO  = 4;
  localparam int STS_LOST = 5;

  localparam int CMD_SEL_LSB = 0;
  localparam int CMD_SEL_W   = 3;
  localparam int CMD_UPDOWN  = 3;
  localparam int CMD_CNT_LSB = 4;
  localparam int CMD_CNT_W   = 8;
  localparam int CMD_W       = 12;
  localparam int CMD_IEN     = 15;

  // Field order matches STATUS bits 5..2 so the W1C mask maps directly.
  typedef struct packed {
    logic lock_lost;
    logic timeout_err;
    logic cmd_rej;
    logic done;
  } sticky_t;

  function automatic logic [CMD_CNT_W-1:0] cmd_count(input logic [CMD_W-1:0] c);
    return c[CMD_CNT_LSB +: CMD_CNT_W];
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the PLL locked indication, cleared to 0 on reset.
module pll_lock_sync (
  input  logic clk,
  input  logic areset_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/pll_phase_step_ctrl.sv
// Avalon-MM sequencer driving the altpll dynamic phase-shift handshake.
// Define PLL_PHASE_IRQ_EN to add the irq output and the busy-writable CMD[15] enable.
module pll_phase_step_ctrl
  import pll_phase_pkg::*;
#(
  parameter int unsigned STEP_PULSE_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES    = 1023,
  parameter int unsigned TMR_W             = 10
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        pll_locked,
  input  logic        pll_phasedone,
  output logic        pll_phasestep,
  output logic        pll_phaseupdown,
  output logic [2:0]  pll_phasecounterselect
`ifdef PLL_PHASE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned PULSE_W = $clog2(STEP_PULSE_CYCLES);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(STEP_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .async_i  (pll_locked),
    .sync_o   (lock_s)
  );

  state_e                 state_q, state_d;
  logic [PULSE_W-1:0]     pulse_q, pulse_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [CMD_CNT_W-1:0]   remain_q, remain_d;
  logic [CMD_W-1:0]       cmd_q, cmd_d;
  logic [CMD_SEL_W-1:0]   sel_q, sel_d;
  logic                   updown_q, updown_d;
  sticky_t                sticky_q, sticky_d, sticky_set, sticky_clr;

  logic             cmd_wr, sts_wr, cmd_ok, cmd_rej;
  logic [CMD_W-1:0] wr_cmd;
  logic [15:0]      cmd_rd;
  logic             unused_bits;

  assign wr_cmd = writedata[CMD_W-1:0];
  assign cmd_wr = chipselect && write && (address == ADDR_CMD);
  assign sts_wr = chipselect && write && (address == ADDR_STATUS);
  assign cmd_ok = cmd_wr && (state_q == IDLE) && lock_s && (cmd_count(wr_cmd) != '0);
`ifdef PLL_PHASE_IRQ_EN
  // A busy-time CMD write only retargets the interrupt enable, so it is not a rejection.
  assign cmd_rej = cmd_wr && (state_q == IDLE) && !cmd_ok;
`else
  assign cmd_rej = cmd_wr && !cmd_ok;
`endif

  // Reads have no side effects, and CMD[14:12] never holds state.
  assign unused_bits = ^{read, writedata[15:CMD_W]};

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pulse_d    = '0;
    tmr_d      = '0;
    remain_d   = remain_q;
    cmd_d      = cmd_q;
    sel_d      = sel_q;
    updown_d   = updown_q;
    sticky_set = '0;
    sticky_set.cmd_rej = cmd_rej;

    if (cmd_ok) begin
      cmd_d    = wr_cmd;
      remain_d = cmd_count(wr_cmd);
    end

    unique case (state_q)
      IDLE: if (cmd_ok) state_d = SETUP;
      SETUP: begin
        sel_d    = cmd_q[CMD_SEL_LSB +: CMD_SEL_W];
        updown_d = cmd_q[CMD_UPDOWN];
        state_d  = STEP;
      end
      STEP: begin
        if (pulse_q == PULSE_LAST) state_d = WAIT_LOW;
        else                       pulse_d = pulse_q + 1'b1;
      end
      WAIT_LOW: begin
        if (!pll_phasedone) begin
          state_d = WAIT_HIGH;
        end else if (tmr_q >= TMR_LAST) begin
          state_d = IDLE;
          sticky_set.timeout_err = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (pll_phasedone) begin
          state_d = NEXT;
        end else if (tmr_q >= TMR_LAST) begin
          state_d = IDLE;
          sticky_set.timeout_err = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      NEXT: begin
        if (remain_q != '0) remain_d = remain_q - 1'b1;
        if (remain_q <= 8'd1) begin
          state_d = IDLE;
          sticky_set.done = 1'b1;
        end else begin
          state_d = STEP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing lock overrides any step in flight; the unfinished count stays readable.
    if ((state_q != IDLE) && !lock_s) begin
      state_d    = IDLE;
      remain_d   = remain_q;
      sticky_set.done        = 1'b0;
      sticky_set.timeout_err = 1'b0;
      sticky_set.lock_lost   = 1'b1;
    end
  end

  always_comb begin
    sticky_clr = sts_wr ? sticky_t'(writedata[STS_LOST:STS_DONE]) : '0;
    sticky_clr.done = sticky_clr.done | cmd_ok;
    // Set is OR-ed after the clear so a same-cycle set wins.
    sticky_d = sticky_set | (sticky_q & ~sticky_clr);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      pulse_q  <= '0;
      tmr_q    <= '0;
      remain_q <= '0;
      cmd_q    <= '0;
      sel_q    <= '0;
      updown_q <= 1'b0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      tmr_q    <= tmr_d;
      remain_q <= remain_d;
      cmd_q    <= cmd_d;
      sel_q    <= sel_d;
      updown_q <= updown_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef PLL_PHASE_IRQ_EN
  logic ien_q, ien_d, irq_q;

  always_comb begin
    ien_d = ien_q;
    if (cmd_ok || (cmd_wr && (state_q != IDLE))) ien_d = writedata[CMD_IEN];
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq_q <= ien_q && (sticky_q.done || sticky_q.timeout_err || sticky_q.lock_lost);
    end
  end

  assign irq    = irq_q;
  assign cmd_rd = {ien_q, 3'b000, cmd_q};
`else
  assign cmd_rd = {4'b0000, cmd_q};
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: readdata = {10'b0, sticky_q, lock_s, (state_q != IDLE)};
      ADDR_CMD:    readdata = cmd_rd;
      ADDR_REMAIN: readdata = {8'b0, remain_q};
      default:     readdata = '0;
    endcase
  end

  // Gated by lock_s so the pulse drops in the very cycle lock loss is seen.
  assign pll_phasestep          = (state_q == STEP) && lock_s;
  assign pll_phaseupdown        = updown_q;
  assign pll_phasecounterselect = sel_q;

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Self-checking bench for pll_phase_step_ctrl with a behavioural PLL phasedone responder.
module tb_pll_phase_step_ctrl;
  import pll_phase_pkg::*;

  localparam int STEP_PULSE_CYCLES = 2;
  localparam int TIMEOUT_CYCLES    = 1023;
`ifdef PLL_PHASE_IRQ_EN
  localparam logic [15:0] CMD_MASK = 16'h8FFF;
`else
  localparam logic [15:0] CMD_MASK = 16'h0FFF;
`endif

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = 16'h0;
  logic [15:0] readdata;
  logic        pll_locked = 1'b1;
  logic        pll_phasedone;
  logic        pll_phasestep;
  logic        pll_phaseupdown;
  logic [2:0]  pll_phasecounterselect;
`ifdef PLL_PHASE_IRQ_EN
  logic        irq;
`endif

  pll_phase_step_ctrl #(
    .STEP_PULSE_CYCLES (STEP_PULSE_CYCLES),
    .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
    .TMR_W             (10)
  ) dut (
    .clk                    (clk),
    .areset_n               (areset_n),
    .address                (address),
    .chipselect             (chipselect),
    .read                   (read),
    .write                  (write),
    .writedata              (writedata),
    .readdata               (readdata),
    .pll_locked             (pll_locked),
    .pll_phasedone          (pll_phasedone),
    .pll_phasestep          (pll_phasestep),
    .pll_phaseupdown        (pll_phaseupdown),
    .pll_phasecounterselect (pll_phasecounterselect)
`ifdef PLL_PHASE_IRQ_EN
    ,
    .irq                    (irq)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: cycle index of every phasestep rise, and count of wrong-width pulses.
  int rise_q[$];
  int width_bad = 0;
  initial begin : monitor
    bit prev;
    int w;
    prev = 1'b0;
    w = 0;
    forever begin
      @(negedge clk);
      if (pll_phasestep) begin
        if (!prev) begin
          rise_q.push_back(cyc);
          w = 0;
        end
        w++;
      end else if (prev && (w != STEP_PULSE_CYCLES)) begin
        width_bad++;
      end
      prev = pll_phasestep;
    end
  end

  // PLL model: phasedone drops d_lo cycles after phasestep falls, returns d_hi later.
  // hs_mode 0 = normal, 1 = phasedone stuck high, 2 = hold low after fall number hold_at.
  int hs_mode = 0;
  int d_lo = 2;
  int d_hi = 4;
  int hold_at = -1;
  int falls = 0;
  bit hs_release = 1'b0;
  initial begin : pll_model
    bit prev;
    prev = 1'b0;
    pll_phasedone = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !pll_phasestep) begin
        falls++;
        if (hs_mode != 1) begin
          repeat (d_lo) @(negedge clk);
          pll_phasedone = 1'b0;
          if (hs_mode == 2 && falls == hold_at) begin
            while (!hs_release) @(negedge clk);
          end else begin
            repeat (d_hi) @(negedge clk);
          end
          pll_phasedone = 1'b1;
        end
      end
      prev = pll_phasestep;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d, output int t);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    t = cyc;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; address = 3'd0; writedata = 16'h0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    address = a; read = 1'b1; chipselect = 1'b1;
    #1;
    d = readdata;
    address = 3'd0; read = 1'b0; chipselect = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    logic [15:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      bus_rd(ADDR_STATUS, s);
      if (!s[STS_BUSY]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_sticky();
    int t;
    bus_wr(ADDR_STATUS, 16'h003C, t);
    @(negedge clk);
  endtask

  // Reference behaviour of one command: cnt pulses of fixed width, first rise two
  // cycles after the write cycle, then idle with done+lock, REMAIN 0, CMD echoed.
  task automatic run_cmd(input logic [2:0] sel, input logic up, input logic [7:0] cnt,
                         input logic ien, input string tag);
    logic [15:0] wd, s;
    int t, p0, w0;
    bit ok;
    wd = {ien, 3'b000, cnt, up, sel};
    p0 = rise_q.size();
    w0 = width_bad;
    bus_wr(ADDR_CMD, wd, t);
    @(negedge clk);
    n_cmp++;
    if (pll_phasecounterselect !== sel || pll_phaseupdown !== up) begin
      n_err++;
      $display("FAIL %s sel/updown: got %0d/%0b want %0d/%0b", tag,
               pll_phasecounterselect, pll_phaseupdown, sel, up);
    end
    wait_idle(int'(cnt) * 20 + 20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s busy_timeout: still busy, want idle", tag);
    end
    n_cmp++;
    if (rise_q.size() - p0 != int'(cnt)) begin
      n_err++;
      $display("FAIL %s pulse_count: got %0d want %0d", tag, rise_q.size() - p0, cnt);
    end
    n_cmp++;
    if (rise_q.size() <= p0 || rise_q[p0] != t + 2) begin
      n_err++;
      $display("FAIL %s first_rise: got cycle %0d want %0d", tag,
               (rise_q.size() > p0) ? rise_q[p0] : -1, t + 2);
    end
    n_cmp++;
    if (width_bad != w0) begin
      n_err++;
      $display("FAIL %s pulse_width: got %0d bad pulses want 0", tag, width_bad - w0);
    end
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0006) begin
      n_err++;
      $display("FAIL %s status: got 0x%04h want 0x0006", tag, s);
    end
    bus_rd(ADDR_REMAIN, s);
    n_cmp++;
    if (s !== 16'h0000) begin
      n_err++;
      $display("FAIL %s remain: got 0x%04h want 0x0000", tag, s);
    end
    bus_rd(ADDR_CMD, s);
    n_cmp++;
    if (s !== (wd & CMD_MASK)) begin
      n_err++;
      $display("FAIL %s cmd_readback: got 0x%04h want 0x%04h", tag, s, wd & CMD_MASK);
    end
  endtask

  task automatic test_reset();
    logic [15:0] s;
    int t;
    @(negedge clk);
    n_cmp++;
    if (pll_phasestep !== 1'b0 || pll_phasecounterselect !== 3'd0 || pll_phaseupdown !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got step=%0b sel=%0d ud=%0b want 0/0/0",
               pll_phasestep, pll_phasecounterselect, pll_phaseupdown);
    end
    for (int a = 0; a < 3; a++) begin
      bus_rd(3'(a), s);
      n_cmp++;
      if (s !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_reg%0d: got 0x%04h want 0x0000", a, s);
      end
    end
    areset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0002) begin
      n_err++;
      $display("FAIL post_reset_status: got 0x%04h want 0x0002", s);
    end
    bus_wr(3'd5, 16'hFFFF, t);
    bus_rd(3'd5, s);
    n_cmp++;
    if (s !== 16'h0000) begin
      n_err++;
      $display("FAIL unmapped_read: got 0x%04h want 0x0000", s);
    end
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0002) begin
      n_err++;
      $display("FAIL unmapped_write_side_effect: got 0x%04h want 0x0002", s);
    end
  endtask

  task automatic test_random_cmds();
    for (int i = 0; i < 5; i++) begin
      d_lo = int'($urandom_range(1, 4));
      d_hi = int'($urandom_range(1, 5));
      run_cmd(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              8'($urandom_range(1, 6)), 1'b0, "random");
    end
  endtask

  task automatic test_reject();
    logic [15:0] s, c0, orig, want_cmd;
    int t, p0;
    bit ok, want_rej;
    clear_sticky();
    bus_rd(ADDR_CMD, c0);
    p0 = rise_q.size();
    bus_wr(ADDR_CMD, 16'h0007, t);
    repeat (4) @(negedge clk);
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h000A) begin
      n_err++;
      $display("FAIL rej_count0_status: got 0x%04h want 0x000A", s);
    end
    bus_rd(ADDR_CMD, s);
    n_cmp++;
    if (s !== c0 || rise_q.size() != p0) begin
      n_err++;
      $display("FAIL rej_count0_effect: got cmd 0x%04h pulses %0d want 0x%04h 0", s,
               rise_q.size() - p0, c0);
    end
    bus_wr(ADDR_STATUS, 16'h0008, t);
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0002) begin
      n_err++;
      $display("FAIL rej_w1c: got 0x%04h want 0x0002", s);
    end

    d_lo = 2; d_hi = 4;
    orig = 16'h0032;
    p0 = rise_q.size();
    bus_wr(ADDR_CMD, orig, t);
    repeat (2) @(negedge clk);
    bus_wr(ADDR_CMD, 16'h8053, t);
`ifdef PLL_PHASE_IRQ_EN
    want_rej = 1'b0;
    want_cmd = orig | 16'h8000;
`else
    want_rej = 1'b1;
    want_cmd = orig;
`endif
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s[STS_REJ] !== want_rej || s[STS_BUSY] !== 1'b1) begin
      n_err++;
      $display("FAIL rej_busy_status: got 0x%04h want rej=%0b busy=1", s, want_rej);
    end
    bus_rd(ADDR_CMD, s);
    n_cmp++;
    if (s !== want_cmd) begin
      n_err++;
      $display("FAIL rej_busy_cmd: got 0x%04h want 0x%04h", s, want_cmd);
    end
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || rise_q.size() - p0 != 3) begin
      n_err++;
      $display("FAIL rej_busy_run: got idle=%0b pulses=%0d want 1 3", ok, rise_q.size() - p0);
    end
    clear_sticky();

    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    bus_rd(ADDR_CMD, c0);
    p0 = rise_q.size();
    bus_wr(ADDR_CMD, 16'h0011, t);
    repeat (3) @(negedge clk);
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0008) begin
      n_err++;
      $display("FAIL rej_unlocked_status: got 0x%04h want 0x0008", s);
    end
    bus_rd(ADDR_CMD, s);
    n_cmp++;
    if (s !== c0 || rise_q.size() != p0) begin
      n_err++;
      $display("FAIL rej_unlocked_effect: got cmd 0x%04h pulses %0d want 0x%04h 0", s,
               rise_q.size() - p0, c0);
    end
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    clear_sticky();
  endtask

  task automatic test_timeout();
    logic [15:0] s;
    logic [2:0] sel;
    int t, w, b;
    bit seen_hi, ok;
    sel = 3'($urandom_range(0, 7));
    hs_mode = 1;
    bus_wr(ADDR_CMD, {8'h00, 8'd2} << 4 | {12'h0, 1'b1, sel}, t);
    seen_hi = 1'b0;
    ok = 1'b0;
    w = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pll_phasestep) seen_hi = 1'b1;
      else if (seen_hi) begin
        ok = 1'b1;
        w = cyc;
        break;
      end
    end
    b = 0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        bus_rd(ADDR_STATUS, s);
        if (!s[STS_BUSY]) begin
          ok = 1'b1;
          b = cyc;
          break;
        end
      end
    end
    n_cmp++;
    if (!ok || b - w != TIMEOUT_CYCLES) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d (ok=%0b) want %0d", b - w, ok, TIMEOUT_CYCLES);
    end
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0012) begin
      n_err++;
      $display("FAIL timeout_status: got 0x%04h want 0x0012", s);
    end
    bus_rd(ADDR_REMAIN, s);
    n_cmp++;
    if (s !== 16'h0002) begin
      n_err++;
      $display("FAIL timeout_remain: got 0x%04h want 0x0002", s);
    end
    hs_mode = 0;
    clear_sticky();
  endtask

  task automatic test_lock_loss();
    logic [15:0] s;
    int t;
    bit ok;
    d_lo = 2; d_hi = 4;
    hold_at = falls + 2;
    hs_mode = 2;
    bus_wr(ADDR_CMD, 16'h0049, t);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (falls >= hold_at && !pll_phasedone) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (!ok || s !== 16'h0003) begin
      n_err++;
      $display("FAIL lost_edge1: got 0x%04h (reached=%0b) want 0x0003", s, ok);
    end
    @(negedge clk);
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0001 || pll_phasestep !== 1'b0) begin
      n_err++;
      $display("FAIL lost_edge2: got 0x%04h step=%0b want 0x0001 0", s, pll_phasestep);
    end
    @(negedge clk);
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0020 || pll_phasestep !== 1'b0) begin
      n_err++;
      $display("FAIL lost_edge3: got 0x%04h step=%0b want 0x0020 0", s, pll_phasestep);
    end
    bus_rd(ADDR_REMAIN, s);
    n_cmp++;
    if (s !== 16'h0003) begin
      n_err++;
      $display("FAIL lost_remain: got 0x%04h want 0x0003", s);
    end
    hs_release = 1'b1;
    pll_locked = 1'b1;
    repeat (8) @(negedge clk);
    hs_release = 1'b0;
    hs_mode = 0;
    clear_sticky();
  endtask

  task automatic test_async_reset();
    logic [15:0] s;
    int t;
    bit ok;
    d_lo = 2; d_hi = 4;
    bus_wr(ADDR_CMD, 16'h003D, t);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pll_phasestep) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    areset_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || pll_phasestep !== 1'b0) begin
      n_err++;
      $display("FAIL areset_step: got step=%0b (was_high=%0b) want 0", pll_phasestep, ok);
    end
    bus_rd(ADDR_STATUS, s);
    n_cmp++;
    if (s !== 16'h0000) begin
      n_err++;
      $display("FAIL areset_status: got 0x%04h want 0x0000", s);
    end
    bus_rd(ADDR_REMAIN, s);
    n_cmp++;
    if (s !== 16'h0000) begin
      n_err++;
      $display("FAIL areset_remain: got 0x%04h want 0x0000", s);
    end
    @(negedge clk);
    areset_n = 1'b1;
    repeat (12) @(negedge clk);
    run_cmd(3'd6, 1'b0, 8'd2, 1'b0, "after_reset");
  endtask

`ifdef PLL_PHASE_IRQ_EN
  task automatic test_irq();
    logic [15:0] s;
    int t;
    bit found;
    clear_sticky();
    d_lo = 2; d_hi = 4;
    bus_wr(ADDR_CMD, 16'h8019, t);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus_rd(ADDR_STATUS, s);
      if (s[STS_DONE]) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found || irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_at_done: got irq=%0b done_seen=%0b want 0 1", irq, found);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_rise: got %0b want 1", irq);
    end
    bus_wr(ADDR_STATUS, 16'h0004, t);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_w1c: got %0b want 0", irq);
    end
  endtask
`endif

  initial begin : main
    test_reset();
    run_cmd(3'd5, 1'b1, 8'd3, 1'b0, "directed_0x0035");
    test_random_cmds();
    test_reject();
    test_timeout();
    test_lock_loss();
    test_async_reset();
`ifdef PLL_PHASE_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
